// File: rtl/clkmon_pkg.sv
// Shared types and helpers for the clkmon clock monitor.
package clkmon_pkg;

  localparam int unsigned MAX_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } clkmon_state_t;

  // |a - b| computed one bit wider than the operands, so it never wraps
  function automatic logic [MAX_CNT_WIDTH:0] abs_diff(
    input logic [MAX_CNT_WIDTH-1:0] a,
    input logic [MAX_CNT_WIDTH-1:0] b
  );
    logic [MAX_CNT_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[MAX_CNT_WIDTH]) d = '0 - d;
    return d;
  endfunction

endpackage

// File: rtl/clkmon_sync.sv
// Synchronizer and rising-edge detector for the monitored clock.
// CLKMON_GLITCH_FILTER_EN adds a filter stage that rejects 1-cycle glitches.
module clkmon_sync (
  input  logic clk,
  input  logic rst,
  input  logic clkin,
  output logic edge_c
);

  logic s1, s2, s3;

  // Flops reset high so a clkin already high at reset release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= clkin;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef CLKMON_GLITCH_FILTER_EN
  logic f, f_new;

  // Level only follows s2 once it has been stable for two samples
  assign f_new = (s2 == s3) ? s2 : f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) f <= 1'b1;
    else     f <= f_new;
  end

  assign edge_c = f_new & ~f;
`else
  assign edge_c = s2 & ~s3;
`endif

endmodule

// File: rtl/clkmon.sv
// Clock monitor: measures the period of clkin in clk cycles and reports lock.
// Build with CLKMON_GLITCH_FILTER_EN to enable the glitch filter in clkmon_sync.
module clkmon
  import clkmon_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned EXPECT_PERIOD = 100,
  parameter int unsigned TOLERANCE     = 2,
  parameter int unsigned LOCK_COUNT    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkin,
  output logic                 rise,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam int unsigned MCNT_WIDTH = (LOCK_COUNT == 0) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [MCNT_WIDTH-1:0] MCNT_LOCK = MCNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH:0]    TOL       = (CNT_WIDTH + 1)'(TOLERANCE);

  if (CNT_WIDTH < 2 || CNT_WIDTH > MAX_CNT_WIDTH || LOCK_COUNT == 0 ||
      64'(EXPECT_PERIOD) + 64'(TOLERANCE) >= (64'd1 << CNT_WIDTH) - 64'd1) begin : g_param_check
    $error("clkmon: illegal parameter combination");
  end

  logic                  edge_c;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH:0]    diff_c;
  logic                  match_c;
  logic [MCNT_WIDTH-1:0] mcnt;
  logic [MCNT_WIDTH-1:0] mcnt_inc_c;
  clkmon_state_t         state;

  clkmon_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .clkin  (clkin),
    .edge_c (edge_c)
  );

  // Period counter: restarts at 1 on each edge, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (edge_c)         cnt <= CNT_WIDTH'(1);
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_WIDTH'(1);
  end

  assign diff_c     = (CNT_WIDTH + 1)'(abs_diff(MAX_CNT_WIDTH'(cnt), MAX_CNT_WIDTH'(EXPECT_PERIOD)));
  assign match_c    = (diff_c <= TOL);
  assign mcnt_inc_c = mcnt + MCNT_WIDTH'(1);

  // Lock FSM with registered outputs; an edge takes priority over saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mcnt         <= '0;
      rise         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      rise         <= edge_c;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (edge_c) begin
        if (state != IDLE) begin
          period       <= cnt;
          period_valid <= 1'b1;
        end
        case (state)
          IDLE: state <= MEASURE;
          MEASURE: begin
            if (match_c) begin
              mcnt <= mcnt_inc_c;
              if (mcnt_inc_c == MCNT_LOCK) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              mcnt <= '0;
            end
          end
          LOCKED: begin
            if (!match_c) begin
              state  <= MEASURE;
              locked <= 1'b0;
              mcnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (cnt == CNT_MAX && state != IDLE) begin
        state   <= IDLE;
        timeout <= 1'b1;
        locked  <= 1'b0;
        mcnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clkmon.sv
// Directed self-checking bench for clkmon (CNT_WIDTH 8, expected period 100 +/- 2).
module tb_clkmon;
  import clkmon_pkg::*;

  localparam int unsigned CW = 8;
`ifdef CLKMON_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clkin;
  logic          rise, period_valid, locked, timeout;
  logic [CW-1:0] period;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rise   = 0;
  int   n_to     = 0;
  int   pv_q[$];
  logic lk_q[$];

  // pv sequence and locked level expected with each period_valid
  int exp_pv[18] = '{100, 100, 100, 100, 100, 97, 100, 100, 100,
                     100, 103, 98, 102, 103, 100, 98, 102, 100};
  int exp_lk[18] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};

  clkmon #(
    .CNT_WIDTH     (CW),
    .EXPECT_PERIOD (100),
    .TOLERANCE     (2),
    .LOCK_COUNT    (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .clkin        (clkin),
    .rise         (rise),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle and record output events at the falling edge
  task automatic tick();
    @(negedge clk);
    if (rise) n_rise++;
    if (timeout) n_to++;
    if (period_valid) begin
      pv_q.push_back(int'(period));
      lk_q.push_back(locked);
    end
  endtask

  task automatic half(input logic lvl, input int n);
    clkin = lvl;
    repeat (n) tick();
  endtask

  task automatic period_of(input int p);
    half(1'b1, p / 2);
    half(1'b0, p - p / 2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rise"}, int'(rise), 0);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_pv"}, int'(period_valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int rise_at, to_at, r0, p0, t0;

    rst   = 1'b1;
    clkin = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (20) tick();
    check("no_rise_at_release", n_rise, 0);
    half(1'b0, 30);

    // First edge: latency from clkin rising to the rise pulse
    clkin = 1'b1;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      check("rise_latency", int'(rise), (t == LAT) ? 1 : 0);
    end
    check("first_edge_no_pv", pv_q.size(), 0);
    half(1'b1, 50 - LAT);
    half(1'b0, 50);
    for (int i = 1; i < 18; i++) period_of(exp_pv[i]);

    // Final edge, then clkin stuck high until timeout
    t0      = n_to;
    rise_at = -1;
    to_at   = -1;
    clkin   = 1'b1;
    for (int t = 1; t <= 400; t++) begin
      tick();
      if (rise && rise_at < 0) rise_at = t;
      if (timeout && to_at < 0) to_at = t;
    end
    check("pv_count", pv_q.size(), 18);
    for (int i = 0; i < 18 && i < pv_q.size(); i++) begin
      check($sformatf("period_%0d", i), pv_q[i], exp_pv[i]);
      check($sformatf("locked_%0d", i), int'(lk_q[i]), exp_lk[i]);
    end
    check("rise_count", n_rise, 19);
    check("timeout_pulses", n_to - t0, 1);
    check("timeout_delay", to_at - rise_at, 255);
    check("locked_after_timeout", int'(locked), 0);
    check("state_after_timeout", int'(u_dut.state), int'(IDLE));

    // After timeout the first edge has no reference period
    p0 = pv_q.size();
    r0 = n_rise;
    half(1'b0, 20);
    period_of(100);
    check("no_pv_after_timeout", pv_q.size(), p0);
    check("rise_after_timeout", n_rise, r0 + 1);
    repeat (4) period_of(100);
    check("relock_pv_count", pv_q.size(), p0 + 4);
    check("relock_locked", int'(locked), 1);

    // Reset in the middle of a locked period
    half(1'b1, 50);
    half(1'b0, 20);
    check("period_before_reset", int'(period), 100);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    r0 = n_rise;
    p0 = pv_q.size();
    clkin = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("no_pulse_around_reset", n_rise, r0);
    check("no_pv_around_reset", pv_q.size(), p0);
    half(1'b0, 50);
    repeat (3) period_of(100);
    clkin = 1'b1;
    repeat (10) tick();
    check("restart_pv_count", pv_q.size(), p0 + 3);
    check("restart_period", (pv_q.size() > 0) ? pv_q[$] : -1, 100);
    check("restart_locked", int'(locked), 0);

    // One-cycle clkin pulse
    rst   = 1'b1;
    clkin = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    r0 = n_rise;
    clkin = 1'b1;
    tick();
    clkin = 1'b0;
    repeat (10) tick();
`ifdef CLKMON_GLITCH_FILTER_EN
    check("glitch_rise", n_rise, r0);
`else
    check("glitch_rise", n_rise, r0 + 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
